// File: rtl/instr_reg_sequencer_if.sv
// Shared types for the instruction-register sequencer and the bundle of
// request, register-port and response signals it connects to.
package instr_reg_sequencer_pkg;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned OPND_W  = 32;
  localparam int unsigned RES_W   = 64;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OPND_W-1:0] operand_t;
  typedef logic [ADDR_W-1:0]        address_t;
  typedef logic signed [RES_W-1:0]  result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;
endpackage

interface instr_reg_sequencer_if;
  import instr_reg_sequencer_pkg::*;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  opcode_t  [NUM_REQ-1:0] req_opcode;
  operand_t [NUM_REQ-1:0] req_operand_a;
  operand_t [NUM_REQ-1:0] req_operand_b;

  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     write_pointer;
  address_t     read_pointer;
  instruction_t instruction_word;

  logic     resp_valid;
  logic     resp_ready;
  logic     resp_id;
  address_t resp_addr;
  result_t  resp_result;
  logic     wrapped;

  // Sequencer side
  modport master (
    input  req_valid, req_opcode, req_operand_a, req_operand_b,
    input  instruction_word, resp_ready,
    output req_ready, load_en, opcode, operand_a, operand_b,
    output write_pointer, read_pointer,
    output resp_valid, resp_id, resp_addr, resp_result, wrapped
  );

  // Requesters, response consumer and instruction register side
  modport slave (
    output req_valid, req_opcode, req_operand_a, req_operand_b,
    output instruction_word, resp_ready,
    input  req_ready, load_en, opcode, operand_a, operand_b,
    input  write_pointer, read_pointer,
    input  resp_valid, resp_id, resp_addr, resp_result, wrapped
  );
endinterface

// File: rtl/instr_reg_sequencer.sv
// Round-robin two-requester front end for the instruction register: grant,
// load one entry, read it back and hand the stored result to the winner.
module instr_reg_sequencer
  import instr_reg_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_reg_sequencer_if.master  bus
);

  localparam address_t LAST_ADDR  = address_t'(DEPTH - 1);
  localparam address_t FIRST_ADDR = address_t'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t   state;
  address_t wp;
  logic     prio;
  logic     id_q;

  logic     grant_c;
  logic     winner_c;

  // Grant is only offered in IDLE; priority holder wins if it is asking.
  always_comb begin
    winner_c      = prio;
    grant_c       = 1'b0;
    bus.req_ready = '0;
    if (!bus.req_valid[prio]) winner_c = ~prio;
    if (reset_n && (state == IDLE) && (bus.req_valid != '0)) grant_c = 1'b1;
    if (grant_c) bus.req_ready[winner_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      wp                <= FIRST_ADDR;
      prio              <= 1'b0;
      id_q              <= 1'b0;
      bus.load_en       <= 1'b0;
      bus.opcode        <= ZERO;
      bus.operand_a     <= '0;
      bus.operand_b     <= '0;
      bus.write_pointer <= '0;
      bus.read_pointer  <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_id       <= 1'b0;
      bus.resp_addr     <= '0;
      bus.resp_result   <= '0;
      bus.wrapped       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_c) begin
            bus.load_en       <= 1'b1;
            bus.opcode        <= bus.req_opcode[winner_c];
            bus.operand_a     <= bus.req_operand_a[winner_c];
            bus.operand_b     <= bus.req_operand_b[winner_c];
            bus.write_pointer <= wp;
            id_q              <= winner_c;
            prio              <= ~winner_c;
            state             <= WRITE;
          end
        end
        WRITE: begin
          bus.load_en      <= 1'b0;
          bus.opcode       <= ZERO;
          bus.operand_a    <= '0;
          bus.operand_b    <= '0;
          bus.read_pointer <= wp;
          state            <= READ;
        end
        READ: begin
          bus.resp_result <= bus.instruction_word.result;
          bus.resp_addr   <= wp;
          bus.resp_id     <= id_q;
          bus.resp_valid  <= 1'b1;
          if (wp == LAST_ADDR) begin
            wp          <= '0;
            bus.wrapped <= 1'b1;
          end else begin
            wp <= wp + address_t'(1);
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_sequencer.sv
// Bench for instr_reg_sequencer: behavioural instruction register, transaction
// level reference model checked every cycle, plus literal expectations.
module tb_instr_reg_sequencer;
  import instr_reg_sequencer_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned BASE  = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_reg_sequencer_if bus ();

  instr_reg_sequencer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endfunction

  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    result_t x, y;
    x = a;
    y = b;
    case (o)
      PASSA:   return x;
      PASSB:   return y;
      ADD:     return x + y;
      SUB:     return x - y;
      MULT:    return x * y;
      DIV:     return (y == 0) ? result_t'(0) : x / y;
      MOD:     return (y == 0) ? result_t'(0) : x % y;
      default: return result_t'(0);
    endcase
  endfunction

  // Instruction register stand-in: write on load_en, combinational readback
  instruction_t regs [DEPTH];
  always @(posedge clk)
    if (bus.load_en)
      regs[bus.write_pointer] <= '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b,
                                   result: calc(bus.opcode, bus.operand_a, bus.operand_b)};
  always_comb bus.instruction_word = regs[bus.read_pointer];

  typedef struct { int id; int addr; longint res; int cyc; } obs_t;
  obs_t obs [$];

  // Transaction-level reference: one outstanding op, timed from its handshake
  initial begin
    int m_prio, m_wp, m_rp, m_hs, win;
    bit m_busy, m_wrapped, t_wrap, exp_v;
    int t_id, t_addr;
    opcode_t t_opc;
    operand_t t_a, t_b;
    result_t t_res;
    logic [1:0] er;
    obs_t o;
    m_prio = 0; m_wp = BASE; m_rp = 0; m_hs = 0; m_busy = 0; m_wrapped = 0;
    t_id = 0; t_addr = 0; t_wrap = 0; t_opc = ZERO; t_a = '0; t_b = '0; t_res = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_prio = 0; m_wp = BASE; m_rp = 0; m_busy = 0; m_wrapped = 0;
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        chk("rst_load_en", 64'(bus.load_en), 0);
        chk("rst_wptr", 64'(bus.write_pointer), 0);
        chk("rst_rptr", 64'(bus.read_pointer), 0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 0);
        chk("rst_resp_result", 64'(bus.resp_result), 0);
        chk("rst_wrapped", 64'(bus.wrapped), 0);
      end else begin
        win = -1;
        er  = '0;
        if (!m_busy && bus.req_valid != '0) begin
          win = bus.req_valid[m_prio] ? m_prio : 1 - m_prio;
          er[win] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (m_busy && cyc == m_hs + 1) begin
          chk("load_en", 64'(bus.load_en), 1);
          chk("opcode", 64'(bus.opcode), 64'(t_opc));
          chk("operand_a", bus.operand_a, t_a);
          chk("operand_b", bus.operand_b, t_b);
          chk("write_pointer", 64'(bus.write_pointer), 64'(t_addr));
        end else begin
          chk("load_en_idle", 64'(bus.load_en), 0);
          chk("opcode_idle", 64'(bus.opcode), 0);
          chk("operands_idle", {bus.operand_a, bus.operand_b}, 0);
        end
        if (m_busy && cyc == m_hs + 2) m_rp = t_addr;
        chk("read_pointer", 64'(bus.read_pointer), 64'(m_rp));
        exp_v = m_busy && (cyc >= m_hs + 3);
        if (m_busy && cyc == m_hs + 3 && t_wrap) m_wrapped = 1;
        chk("resp_valid", 64'(bus.resp_valid), 64'(exp_v));
        chk("wrapped", 64'(bus.wrapped), 64'(m_wrapped));
        if (exp_v) begin
          chk("resp_id", 64'(bus.resp_id), 64'(t_id));
          chk("resp_addr", 64'(bus.resp_addr), 64'(t_addr));
          chk("resp_result", bus.resp_result, t_res);
          if (bus.resp_ready) begin
            o.id = int'(bus.resp_id); o.addr = int'(bus.resp_addr);
            o.res = longint'(bus.resp_result); o.cyc = cyc;
            obs.push_back(o);
            m_busy = 0;
          end
        end
        if (win >= 0) begin
          t_id = win; t_opc = bus.req_opcode[win];
          t_a = bus.req_operand_a[win]; t_b = bus.req_operand_b[win];
          t_res = calc(t_opc, t_a, t_b);
          t_addr = m_wp; t_wrap = (m_wp == DEPTH - 1);
          m_wp = t_wrap ? 0 : m_wp + 1;
          m_prio = 1 - win; m_hs = cyc; m_busy = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_req(input int id, input opcode_t o, input int a, input int b);
    bus.req_opcode[id]    = o;
    bus.req_operand_a[id] = a;
    bus.req_operand_b[id] = b;
    bus.req_valid[id]     = 1'b1;
  endtask

  task automatic wait_grant(input int id);
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.req_ready[id] && t < 100);
    chk("grant_timeout", 64'(bus.req_ready[id]), 1);
    last_hs = cyc;
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs.size() < n && t < 200) begin step(); t++; end
    chk("resp_timeout", 64'(obs.size() >= n), 1);
  endtask

  task automatic issue(input int id, input opcode_t o, input int a, input int b);
    int n0 = obs.size();
    set_req(id, o, a, b);
    wait_grant(id);
    step();
    bus.req_valid[id] = 1'b0;
    wait_obs(n0 + 1);
  endtask

  task automatic chk_obs(string nm, int idx, int id, int addr, longint res);
    if (idx >= obs.size()) begin
      chk({nm, "_missing"}, 64'(obs.size()), 64'(idx + 1));
    end else begin
      chk({nm, "_id"}, 64'(obs[idx].id), 64'(id));
      chk({nm, "_addr"}, 64'(obs[idx].addr), 64'(addr));
      chk({nm, "_res"}, obs[idx].res, res);
    end
  endtask

  initial begin
    int n0;
    bus.req_valid = '0; bus.resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req_opcode[i] = ZERO; bus.req_operand_a[i] = '0; bus.req_operand_b[i] = '0;
    end
    do_reset();

    // Single ADD after reset
    issue(0, ADD, 5, 3);
    chk_obs("add", 0, 0, 0, 8);
    chk("add_latency", 64'(obs[0].cyc - last_hs), 3);

    // Continuous contention alternates
    do_reset();
    n0 = obs.size();
    set_req(0, SUB, 10, 4);
    set_req(1, MULT, 6, 7);
    wait_obs(n0 + 4);
    bus.req_valid = '0;
    chk_obs("rr0", n0, 0, 0, 6);
    chk_obs("rr1", n0 + 1, 1, 1, 42);
    chk_obs("rr2", n0 + 2, 0, 2, 6);
    chk_obs("rr3", n0 + 3, 1, 3, 42);

    // Division corner cases from requester 1
    n0 = obs.size();
    issue(1, DIV, 9, 0);
    issue(1, DIV, 9, 2);
    issue(1, MOD, 9, 2);
    chk_obs("div0", n0, 1, 4, 0);
    chk_obs("div", n0 + 1, 1, 5, 4);
    chk_obs("mod", n0 + 2, 1, 6, 1);

    // Pointer wrap over 33 operations
    do_reset();
    n0 = obs.size();
    for (int k = 0; k < 33; k++) begin
      issue(0, ADD, k, 1);
      if (k == 30) chk("wrapped_before", 64'(bus.wrapped), 0);
      if (k == 31) chk("wrapped_at_32", 64'(bus.wrapped), 1);
    end
    chk_obs("wrap31", n0 + 31, 0, 31, 32);
    chk_obs("wrap32", n0 + 32, 0, 0, 33);
    chk("wrapped_sticky", 64'(bus.wrapped), 1);

    // Response backpressure with requester 1 waiting
    do_reset();
    n0 = obs.size();
    bus.resp_ready = 1'b0;
    set_req(0, ADD, 1, 2);
    wait_grant(0);
    step();
    bus.req_valid[0] = 1'b0;
    set_req(1, SUB, 20, 5);
    begin
      int t = 0;
      while (!bus.resp_valid && t < 20) begin @(negedge clk); t++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.resp_valid), 1);
      chk("bp_ready", 64'(bus.req_ready), 0);
      chk("bp_result", bus.resp_result, 3);
    end
    step();
    bus.resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_next_grant", 64'(bus.req_ready), 64'(2'b10));
    step();
    bus.req_valid[1] = 1'b0;
    wait_obs(n0 + 2);
    chk_obs("bp_first", n0, 0, 0, 3);
    chk_obs("bp_second", n0 + 1, 1, 1, 15);

    // Reset during WRITE abandons the operation
    issue(0, ADD, 1, 1);
    set_req(0, ADD, 7, 7);
    wait_grant(0);
    step();
    bus.req_valid[0] = 1'b0;
    chk("pre_rst_load_en", 64'(bus.load_en), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_load_en", 64'(bus.load_en), 0);
    chk("arst_wptr", 64'(bus.write_pointer), 0);
    chk("arst_opa", bus.operand_a, 0);
    chk("arst_resp", {63'(bus.resp_addr), bus.resp_valid}, 0);
    chk("arst_wrapped", 64'(bus.wrapped), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n0 = obs.size();
    repeat (6) step();
    chk("no_resp_after_rst", 64'(obs.size()), 64'(n0));
    set_req(0, ADD, 2, 2);
    set_req(1, ADD, 3, 3);
    wait_obs(n0 + 2);
    bus.req_valid = '0;
    chk_obs("post_rst0", n0, 0, BASE, 4);
    chk_obs("post_rst1", n0 + 1, 1, BASE + 1, 6);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
